// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared interrupt controller state type and dispatch vectors
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_DISPATCH = 2'd2
  } int_state_e;

  localparam logic [7:0] VEC_VBLANK = 8'h40;
  localparam logic [7:0] VEC_STAT   = 8'h48;
  localparam logic [7:0] VEC_TIMER  = 8'h50;
  localparam logic [7:0] VEC_SERIAL = 8'h58;
  localparam logic [7:0] VEC_JOYPAD = 8'h60;

  function automatic logic [7:0] vec_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return VEC_VBLANK;
      3'd1:    return VEC_STAT;
      3'd2:    return VEC_TIMER;
      3'd3:    return VEC_SERIAL;
      3'd4:    return VEC_JOYPAD;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/gb_cpu_int_priority.sv
// rtl/gb_cpu_int_priority.sv - lowest-index-wins encoder for the five interrupt sources
module gb_cpu_int_priority (
  input  logic [4:0] req_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  // Scan from the top so the lowest set bit is the last (winning) assignment
  always_comb begin
    idx_o   = 3'd0;
    valid_o = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// rtl/gb_cpu_interrupt_ctrl.sv - IE/IF registers, IME with delayed EI, HALT and dispatch sequencing
module gb_cpu_interrupt_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] irq_req,
  input  logic       reg_wr_en,
  input  logic       reg_sel_ie,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       last_m_cycle,
  input  logic       enable_interrupts,
  input  logic       disable_interrupts,
  input  logic       write_interrupt_vector,
  input  logic       clear_interrupt_flag,
  input  logic       ei_delayed,
  input  logic       isr_cmd,
  input  logic       halt_req,
  output logic       interrupt_queued,
  output logic [7:0] int_vector,
  output logic       ime,
  output logic       halted,
  output logic       halt_bug
);

  int_state_e state_q;
  logic [7:0] ie_q, ie_d;
  logic [4:0] if_q, if_d;
  logic [4:0] sel_q, sel_d;
  logic [7:0] vec_q, vec_d;
  logic       ime_q, ime_d;
  logic       ei_pend_q, ei_pend_d;
  logic       ei_cnt_q, ei_cnt_d;
  logic       ei_promote;
  logic       halt_bug_q;
  logic [4:0] pending;
  logic [2:0] prio_idx;
  logic       prio_valid;

  assign pending = ie_q[4:0] & if_q;

  gb_cpu_int_priority u_prio (
    .req_i   (pending),
    .idx_o   (prio_idx),
    .valid_o (prio_valid)
  );

  always_comb begin
    // Peripheral requests are OR-ed in last so they survive a same-cycle write or clear
    if_d = if_q;
    if (reg_wr_en && !reg_sel_ie) if_d = reg_wdata[4:0];
    if (clear_interrupt_flag)     if_d = if_d & ~sel_q;
    if_d = if_d | irq_req;

    ie_d = (reg_wr_en && reg_sel_ie) ? reg_wdata : ie_q;

    ei_promote = 1'b0;
    ei_pend_d  = ei_pend_q;
    ei_cnt_d   = ei_cnt_q;
    if (disable_interrupts) begin
      ei_pend_d = 1'b0;
    end else if (enable_interrupts && ei_delayed) begin
      ei_pend_d = 1'b1;
      ei_cnt_d  = 1'b0;
    end else if (ei_pend_q && last_m_cycle) begin
      if (ei_cnt_q) begin
        ei_pend_d  = 1'b0;
        ei_promote = 1'b1;
      end else begin
        ei_cnt_d = 1'b1;
      end
    end

    ime_d = ime_q;
    if (disable_interrupts || clear_interrupt_flag)        ime_d = 1'b0;
    else if ((enable_interrupts && !ei_delayed) || ei_promote) ime_d = 1'b1;

    vec_d = vec_q;
    sel_d = sel_q;
    if (write_interrupt_vector) begin
      vec_d = prio_valid ? vec_addr(prio_idx) : 8'h00;
      sel_d = prio_valid ? (5'b00001 << prio_idx) : 5'b00000;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      ie_q       <= 8'h00;
      if_q       <= 5'h00;
      sel_q      <= 5'h00;
      vec_q      <= 8'h00;
      ime_q      <= 1'b0;
      ei_pend_q  <= 1'b0;
      ei_cnt_q   <= 1'b0;
      halt_bug_q <= 1'b0;
    end else begin
      ie_q       <= ie_d;
      if_q       <= if_d;
      sel_q      <= sel_d;
      vec_q      <= vec_d;
      ime_q      <= ime_d;
      ei_pend_q  <= ei_pend_d;
      ei_cnt_q   <= ei_cnt_d;
      halt_bug_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (isr_cmd) begin
            state_q <= ST_DISPATCH;
          end else if (halt_req && last_m_cycle) begin
            // HALT with IME off and something pending never halts; the next fetch repeats
            if (!ime_q && |pending) halt_bug_q <= 1'b1;
            else                    state_q    <= ST_HALT;
          end
        end
        ST_HALT:     if (|pending)            state_q <= ST_RUN;
        ST_DISPATCH: if (clear_interrupt_flag) state_q <= ST_RUN;
        default:                               state_q <= ST_RUN;
      endcase
    end
  end

  assign reg_rdata        = reg_sel_ie ? ie_q : {3'b111, if_q};
  assign interrupt_queued = ime_q && (|pending) && (state_q == ST_RUN);
  assign int_vector       = vec_q;
  assign ime              = ime_q;
  assign halted           = (state_q == ST_HALT);
  assign halt_bug         = halt_bug_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// tb/tb_gb_cpu_interrupt_ctrl.sv - directed vector table plus randomized run against a reference model
module tb_gb_cpu_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] irq_req;
  logic       reg_wr_en, reg_sel_ie;
  logic [7:0] reg_wdata, reg_rdata;
  logic       last_m_cycle, enable_interrupts, disable_interrupts;
  logic       write_interrupt_vector, clear_interrupt_flag, ei_delayed;
  logic       isr_cmd, halt_req;
  logic       interrupt_queued, ime, halted, halt_bug;
  logic [7:0] int_vector;

  always #5 clk = ~clk;

  gb_cpu_interrupt_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .irq_req                (irq_req),
    .reg_wr_en              (reg_wr_en),
    .reg_sel_ie             (reg_sel_ie),
    .reg_wdata              (reg_wdata),
    .reg_rdata              (reg_rdata),
    .last_m_cycle           (last_m_cycle),
    .enable_interrupts      (enable_interrupts),
    .disable_interrupts     (disable_interrupts),
    .write_interrupt_vector (write_interrupt_vector),
    .clear_interrupt_flag   (clear_interrupt_flag),
    .ei_delayed             (ei_delayed),
    .isr_cmd                (isr_cmd),
    .halt_req               (halt_req),
    .interrupt_queued       (interrupt_queued),
    .int_vector             (int_vector),
    .ime                    (ime),
    .halted                 (halted),
    .halt_bug               (halt_bug)
  );

  typedef struct {
    int irq, wr, sel, wd, lm, en, eid, dis, wiv, cif, isr, hlt, rsel;
    int x_rd, x_q, x_vec, x_ime, x_hlt, x_bug;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic idle();
    irq_req = 5'h00; reg_wr_en = 1'b0; reg_sel_ie = 1'b0; reg_wdata = 8'h00;
    last_m_cycle = 1'b0; enable_interrupts = 1'b0; disable_interrupts = 1'b0;
    write_interrupt_vector = 1'b0; clear_interrupt_flag = 1'b0; ei_delayed = 1'b0;
    isr_cmd = 1'b0; halt_req = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    irq_req = 5'(v.irq); reg_wr_en = 1'(v.wr); reg_sel_ie = 1'(v.sel); reg_wdata = 8'(v.wd);
    last_m_cycle = 1'(v.lm); enable_interrupts = 1'(v.en); ei_delayed = 1'(v.eid);
    disable_interrupts = 1'(v.dis); write_interrupt_vector = 1'(v.wiv);
    clear_interrupt_flag = 1'(v.cif); isr_cmd = 1'(v.isr); halt_req = 1'(v.hlt);
  endtask

  task automatic check_outs(input string tag, input int rd, input int q, input int vec,
                            input int im, input int hl, input int bg);
    chk({tag, " rdata"}, reg_rdata, 8'(rd));
    chk({tag, " queued"}, {7'd0, interrupt_queued}, 8'(q));
    chk({tag, " vector"}, int_vector, 8'(vec));
    chk({tag, " ime"}, {7'd0, ime}, 8'(im));
    chk({tag, " halted"}, {7'd0, halted}, 8'(hl));
    chk({tag, " halt_bug"}, {7'd0, halt_bug}, 8'(bg));
  endtask

  // Reference model state: IE, IF, IME, EI edges remaining, state (0 run, 1 halt, 2 dispatch)
  int m_ie, m_if, m_ime, m_eic, m_st, m_vec, m_sel, m_bug;

  task automatic model_step(input int irq, wr, sel, wd, lm, en, eid, dis, wiv, cif, isr, hlt);
    int pend, low, n_if, n_ime, n_eic, n_st;
    pend = m_ie & m_if & 31;
    low = -1;
    for (int b = 0; b < 5; b++) if (low < 0 && ((pend >> b) & 1) == 1) low = b;
    n_if = m_if;
    if (wr == 1 && sel == 0) n_if = wd & 31;
    if (cif == 1 && m_sel >= 0) n_if = n_if & ~(1 << m_sel);
    n_if = n_if | irq;
    if (wr == 1 && sel == 1) m_ie = wd;
    n_ime = m_ime;
    n_eic = m_eic;
    if (dis == 1) begin
      n_ime = 0;
      n_eic = 0;
    end else begin
      if (en == 1 && eid == 1) n_eic = 2;
      else if (m_eic > 0 && lm == 1) begin
        n_eic = m_eic - 1;
        if (n_eic == 0) n_ime = 1;
      end
      if (en == 1 && eid == 0) n_ime = 1;
      if (cif == 1) n_ime = 0;
    end
    m_bug = 0;
    n_st = m_st;
    if (m_st == 0) begin
      if (isr == 1) n_st = 2;
      else if (hlt == 1 && lm == 1) begin
        if (m_ime == 0 && pend != 0) m_bug = 1;
        else n_st = 1;
      end
    end else if (m_st == 1) begin
      if (pend != 0) n_st = 0;
    end else if (cif == 1) begin
      n_st = 0;
    end
    if (wiv == 1) begin
      m_vec = (low >= 0) ? 64 + 8 * low : 0;
      m_sel = low;
    end
    m_if = n_if; m_ime = n_ime; m_eic = n_eic; m_st = n_st;
  endtask

  initial begin
    //            irq wr sel wd    lm en eid dis wiv cif isr hlt rsel  rd    q vec   ime hlt bug
    tbl[0]  = '{0, 1, 1, 'h01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h01, 0, 'h00, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0, 'hE0, 0, 'h00, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE1, 1, 'h00, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 'hE1, 0, 'h00, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 0, 0, 'hE1, 0, 'h40, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 'hE0, 0, 'h40, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 'h1F, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1F, 0, 'h40, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 'h1C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFC, 0, 'h40, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 0, 0, 'hFC, 0, 'h50, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 'hF8, 0, 'h50, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE0, 0, 'h50, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE1, 0, 'h50, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0,    1, 1, 1, 0, 0, 0, 0, 0, 0, 'hE1, 0, 'h50, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 'hE1, 0, 'h50, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE1, 0, 'h50, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 'hE1, 1, 'h50, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0,    0, 0, 0, 1, 0, 0, 0, 0, 0, 'hE1, 0, 'h50, 0, 0, 0};
    tbl[17] = '{0, 1, 1, 'h04, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h04, 0, 'h50, 0, 0, 0};
    tbl[18] = '{0, 1, 0, 'h04, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE4, 0, 'h50, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 1, 0, 'hE4, 0, 'h50, 0, 0, 1};
    tbl[20] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE4, 0, 'h50, 0, 0, 0};
    tbl[21] = '{0, 1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE0, 0, 'h50, 0, 0, 0};
    tbl[22] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 1, 0, 'hE0, 0, 'h50, 0, 1, 0};
    tbl[23] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE0, 0, 'h50, 0, 1, 0};
    tbl[24] = '{4, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE4, 0, 'h50, 0, 1, 0};
    tbl[25] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE4, 0, 'h50, 0, 0, 0};
    tbl[26] = '{0, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0, 'hE4, 1, 'h50, 1, 0, 0};
    tbl[27] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 'hE4, 0, 'h50, 1, 0, 0};
    tbl[28] = '{0, 1, 1, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0, 'h50, 1, 0, 0};
    tbl[29] = '{0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 0, 0, 'hE4, 0, 'h00, 1, 0, 0};
    tbl[30] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 'hE4, 0, 'h00, 0, 0, 0};
    tbl[31] = '{1, 1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hE1, 0, 'h00, 0, 0, 0};
    tbl[32] = '{0, 1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFF, 0, 'h00, 0, 0, 0};

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_if", 'hE0, 0, 'h00, 0, 0, 0);
    reg_sel_ie = 1'b1;
    #1 chk("reset_ie", reg_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    idle();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      idle();
      reg_sel_ie = 1'(tbl[i].rsel);
      #1;
      check_outs($sformatf("v%0d", i), tbl[i].x_rd, tbl[i].x_q, tbl[i].x_vec,
                 tbl[i].x_ime, tbl[i].x_hlt, tbl[i].x_bug);
    end

    // Halt with nothing pending, then pull reset asynchronously between edges
    halt_req = 1'b1;
    last_m_cycle = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("pre_reset halted", {7'd0, halted}, 8'h01);
    #2 reset = 1'b0;
    #1;
    check_outs("async_reset", 'hE0, 0, 'h00, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    m_ie = 0; m_if = 0; m_ime = 0; m_eic = 0; m_st = 0; m_vec = 0; m_sel = -1; m_bug = 0;
    for (int c = 0; c < 400; c++) begin
      int r_irq, r_wr, r_sel, r_wd, r_lm, r_en, r_eid, r_dis, r_wiv, r_cif, r_isr, r_hlt, pn;
      r_irq = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 31)) : 0;
      r_wr  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      r_sel = int'($urandom_range(0, 1));
      r_wd  = int'($urandom_range(0, 255));
      r_lm  = int'($urandom_range(0, 1));
      r_en  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      r_eid = int'($urandom_range(0, 1));
      r_dis = ($urandom_range(0, 11) == 0) ? 1 : 0;
      r_wiv = ($urandom_range(0, 7) == 0) ? 1 : 0;
      r_cif = ($urandom_range(0, 7) == 0) ? 1 : 0;
      r_isr = ($urandom_range(0, 9) == 0) ? 1 : 0;
      r_hlt = ($urandom_range(0, 7) == 0) ? 1 : 0;
      drive('{r_irq, r_wr, r_sel, r_wd, r_lm, r_en, r_eid, r_dis, r_wiv, r_cif, r_isr, r_hlt,
              0, 0, 0, 0, 0, 0, 0});
      model_step(r_irq, r_wr, r_sel, r_wd, r_lm, r_en, r_eid, r_dis, r_wiv, r_cif, r_isr, r_hlt);
      @(posedge clk);
      #1;
      idle();
      reg_sel_ie = 1'($urandom_range(0, 1));
      #1;
      pn = m_ie & m_if & 31;
      check_outs($sformatf("rnd%0d", c), reg_sel_ie ? m_ie : (224 | m_if),
                 (m_ime == 1 && pn != 0 && m_st == 0) ? 1 : 0, m_vec, m_ime,
                 (m_st == 1) ? 1 : 0, m_bug);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
GB_CPU_INTERRUPT_CTRL -- requirements
Module: gb_cpu_interrupt_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  machine (M) clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 irq_req  input  5  peripheral request pulses: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
REQ-005 reg_wr_en  input  1  CPU write strobe to IE/IF.
REQ-006 reg_sel_ie  input  1  1 = IE (0xFFFF), 0 = IF (0xFF0F).
REQ-007 reg_wdata  input  8  CPU write data.
REQ-008 reg_rdata  output  8  read data of selected register, combinational.
REQ-009 last_m_cycle  input  1  current M-cycle ends an instruction (instruction boundary).
REQ-010 enable_interrupts, disable_interrupts, write_interrupt_vector, clear_interrupt_flag  input  1 each  control fields of the current M-cycle.
REQ-011 ei_delayed  input  1  qualifies enable_interrupts: 1 = EI (delayed), 0 = RETI (immediate).
REQ-012 isr_cmd  input  1  scheduler is executing the interrupt dispatch sequence.
REQ-013 halt_req  input  1  HALT opcode executing in this M-cycle.
REQ-014 interrupt_queued  output  1  next instruction SHALL be the ISR dispatch.
REQ-015 int_vector  output  8  latched dispatch address low byte.
REQ-016 ime, halted, halt_bug  output  1 each  master enable, CPU halted, one-cycle halt-bug pulse.

Function
REQ-017 pending[4:0] SHALL equal IE[4:0] & IF[4:0]; interrupt_queued = ime & |pending & state==RUN.
REQ-018 IF bits SHALL be set by irq_req each cycle; a same-cycle request SHALL win over CPU write or clear_interrupt_flag of that bit.
REQ-019 IF reads SHALL return {3'b111, IF[4:0]}; IE SHALL be a full 8-bit register, reads return all 8 bits.
REQ-020 disable_interrupts SHALL clear ime and any pending EI at the next edge.
REQ-021 enable_interrupts with ei_delayed=0 SHALL set ime at the next edge.
REQ-022 enable_interrupts with ei_delayed=1 SHALL set ei_pending; ime SHALL be set on the second subsequent last_m_cycle edge (after the following instruction), so the following instruction cannot be interrupted.
REQ-023 disable_interrupts SHALL take priority over enable_interrupts in the same cycle.
REQ-024 States: RUN, HALT, DISPATCH (2-bit enum).
REQ-025 RUN->HALT on halt_req & last_m_cycle when ~(~ime & |pending); if ~ime & |pending at that edge, state stays RUN and halt_bug SHALL pulse one cycle.
REQ-026 HALT->RUN when |pending regardless of ime; halted = (state==HALT).
REQ-027 RUN->DISPATCH on isr_cmd; DISPATCH->RUN on clear_interrupt_flag edge.
REQ-028 On write_interrupt_vector, int_vector SHALL latch 0x40 + 8*idx of lowest-index pending bit; if pending==0 at that edge (cancelled dispatch) int_vector SHALL latch 0x00.
REQ-029 int_vector SHALL hold its value until the next write_interrupt_vector.
REQ-030 clear_interrupt_flag SHALL clear the IF bit selected at latch time (none if cancelled) and clear ime.
REQ-031 Unused upper IE/IF inputs (irq_req, reg_wdata[7:5] for IF) SHALL have no effect on pending.

Reset
REQ-032 On reset low: IE=8'h00, IF=5'h00, ime=0, ei_pending=0, int_vector=8'h00, state=RUN, halt_bug=0.
REQ-033 Reset mid-dispatch or mid-HALT SHALL return to RUN immediately, no partial IF clear.

Structure
REQ-034 The state enum and vector constants (VEC_VBLANK=0x40 ... VEC_JOYPAD=0x60) SHALL live in gb_cpu_common_pkg.
REQ-035 One sub-module, gb_cpu_int_priority (combinational 5-bit lowest-set-bit encoder with valid), is natural.

Verification
REQ-036 ime=1, IE=0x01, irq_req=5'b00001 -> interrupt_queued=1 next cycle; write_interrupt_vector -> int_vector=0x40; clear_interrupt_flag -> IF reads 0xE0, ime=0.
REQ-037 IE=0x1F, IF=0x1C, write_interrupt_vector -> int_vector=0x50 (Timer wins).
REQ-038 EI (ei_delayed=1) then pending present -> interrupt_queued stays 0 until two last_m_cycle edges elapse, then 1.
REQ-039 ime=0, IE=0x04, IF=0x04, halt_req at boundary -> halt_bug pulse, halted=0; with IF=0, halted=1 until irq_req=0x04, then halted=0, interrupt_queued=0.
REQ-040 During DISPATCH, CPU writes IE=0x00 before write_interrupt_vector -> int_vector=0x00, IF unchanged after clear.
REQ-041 Same-cycle irq_req bit0 and CPU IF write 0x00 -> IF reads 0xE1.
